// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t  : arbiter FSM state encoding (IDLE is all-zero)
//   PORT_CPU : index of the CPU load/store requester
//   PORT_DBG : index of the debug/loader requester
//   LAT_W    : width of the memory latency counter (covers MEM_LAT 1..7)
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   localparam int LAT_W = 3;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the two data-memory requesters.
// Build option: DMEM_ARB_RR_EN selects round-robin (pointer names the
// preferred port when both are valid); otherwise port 1 has fixed priority.
//   valid0, valid1 : request valids of port 0 / port 1
//   ptr            : preferred port (only present with DMEM_ARB_RR_EN)
//   gnt0, gnt1     : one-hot (or zero) grant
module dmem_arb_pick (
   input  logic valid0,
   input  logic valid1,
`ifdef DMEM_ARB_RR_EN
   input  logic ptr,
`endif
   output logic gnt0,
   output logic gnt1
);

`ifdef DMEM_ARB_RR_EN
   // A lone requester always wins; on contention the pointer decides.
   assign gnt1 = valid1 & (~valid0 | ptr);
   assign gnt0 = valid0 & (~valid1 | ~ptr);
`else
   assign gnt1 = valid1;
   assign gnt0 = valid0 & ~valid1;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with a fixed read
// latency of MEM_LAT cycles. Port 0 is the CPU path, port 1 the debug/loader
// path. Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration (default is
// fixed priority, port 1 first).
//
// Handshake: a request transfers in a cycle where reqN_valid & reqN_ready are
// both high. The requester keeps valid/we/addr/wdata stable until then; a
// valid dropped before ready is simply forgotten. ready is only ever high in
// IDLE (and never while rst is high). rspN_valid is a single-cycle strobe,
// and rspN_rdata holds until that port's next response (0 for writes).
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req{0,1}_valid/we/addr/wdata, req{0,1}_ready : request channels
//   rsp{0,1}_valid/rdata     : response channels
//   mem_en/we/addr/wdata, mem_rdata : memory side
//   busy                     : FSM not in IDLE
//   dbg_state                : current FSM state, for observation
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output state_t            dbg_state
);

   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
      $error("dmem_arbiter: MEM_LAT must be in 1..7");
   end

   state_t            state;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [LAT_W-1:0]  lat_cnt;
   logic              gnt0, gnt1;
   logic              acc0, acc1;
   logic              can_accept;

`ifdef DMEM_ARB_RR_EN
   logic ptr_q;

   dmem_arb_pick u_pick (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .ptr    (ptr_q),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );
`else
   dmem_arb_pick u_pick (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );
`endif

   assign can_accept = (state == IDLE) && !rst;
   assign req0_ready = can_accept & gnt0;
   assign req1_ready = can_accept & gnt1;
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;

   assign busy      = (state != IDLE);
   assign dbg_state = state;
   assign mem_en    = (state == ISSUE);
   assign mem_we    = (state == ISSUE) & we_q;
   // The bus shows the latched access for its whole lifetime, zero when idle.
   assign mem_addr  = busy ? addr_q  : '0;
   assign mem_wdata = busy ? wdata_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner_q    <= PORT_CPU;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_cnt    <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
         ptr_q      <= PORT_CPU;
`endif
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (acc0 || acc1) begin
                  owner_q <= acc1 ? PORT_DBG : PORT_CPU;
                  we_q    <= acc1 ? req1_we    : req0_we;
                  addr_q  <= acc1 ? req1_addr  : req0_addr;
                  wdata_q <= acc1 ? req1_wdata : req0_wdata;
`ifdef DMEM_ARB_RR_EN
                  // Prefer the port that lost (or did not ask) this time.
                  ptr_q   <= acc0;
`endif
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               lat_cnt <= LAT_W'(MEM_LAT - 1);
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  // Writes return zero so stale bus data never leaks out.
                  if (owner_q == PORT_DBG) begin
                     rsp1_rdata <= we_q ? '0 : mem_rdata;
                     rsp1_valid <= 1'b1;
                  end else begin
                     rsp0_rdata <= we_q ? '0 : mem_rdata;
                     rsp0_valid <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (MEM_LAT = 2, 1, 7); one at a time
// is active via sel. Drivers push expected responses and memory-bus issues
// into queues at accept time; a negedge monitor pops and compares.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int OW = 7 + 4 * 32 + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0v, r0we, r1v, r1we;
   logic [31:0] r0a, r0d, r1a, r1d;
   logic [31:0] m_rdata;
   int          sel;
   int          cur_lat;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          rdy0_hi = 0;

   logic        rdy0, rdy1, s0v, s1v, men, mwe, bsy;
   logic [31:0] s0d, s1d, ma, mwd;
   logic [1:0]  st;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- DUTs
   for (genvar k = 0; k < 3; k++) begin : g_i
      localparam int LAT = (k == 0) ? 2 : (k == 1) ? 1 : 7;
      logic        act;
      logic        o_rdy0, o_rdy1, o_s0v, o_s1v, o_men, o_mwe, o_bsy;
      logic [31:0] o_s0d, o_s1d, o_ma, o_mwd;
      state_t      o_st;
      logic [OW-1:0] o_vec;

      assign act = (sel == k);

      dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req0_valid (r0v & act),
         .req0_we    (r0we),
         .req0_addr  (r0a),
         .req0_wdata (r0d),
         .req0_ready (o_rdy0),
         .rsp0_valid (o_s0v),
         .rsp0_rdata (o_s0d),
         .req1_valid (r1v & act),
         .req1_we    (r1we),
         .req1_addr  (r1a),
         .req1_wdata (r1d),
         .req1_ready (o_rdy1),
         .rsp1_valid (o_s1v),
         .rsp1_rdata (o_s1d),
         .mem_en     (o_men),
         .mem_we     (o_mwe),
         .mem_addr   (o_ma),
         .mem_wdata  (o_mwd),
         .mem_rdata  (m_rdata),
         .busy       (o_bsy),
         .dbg_state  (o_st)
      );

      assign o_vec = {o_rdy0, o_rdy1, o_s0v, o_s1v, o_men, o_mwe, o_bsy,
                      o_s0d, o_s1d, o_ma, o_mwd, o_st};
   end

   logic [OW-1:0] o_vec;
   assign o_vec = (sel == 0) ? g_i[0].o_vec : (sel == 1) ? g_i[1].o_vec : g_i[2].o_vec;
   assign {rdy0, rdy1, s0v, s1v, men, mwe, bsy, s0d, s1d, ma, mwd, st} = o_vec;

   // ------------------------------------------------------- memory model
   // Reads return DEADBEEF at 0x10, else {C0DE, addr[15:0]}. Non-read
   // cycles carry A5A5A5A5 so wrong latency or unmasked writes show up.
   function automatic logic [31:0] model(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
   endfunction

   logic [31:0] pipe [7];
   always @(posedge clk) begin
      pipe[0] <= (men && !mwe) ? model(ma) : 32'hA5A5A5A5;
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
   end
   always_comb m_rdata = pipe[cur_lat-1];

   // --------------------------------------------------------- scoreboard
   typedef struct {
      int          port;
      logic [31:0] data;
      int          cyc;
   } rsp_t;
   typedef struct {
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   rsp_t exp_q[$];
   bus_t bus_q[$];
   rsp_t re;
   bus_t be;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (s0v || s1v) begin
            if (exp_q.size() == 0) flag("unexpected_rsp");
            else begin
               re = exp_q.pop_front();
               chk("rsp_port", s1v ? 32'd1 : 32'd0, re.port);
               chk("rsp_both", {31'd0, s0v & s1v}, 32'd0);
               chk("rsp_cycle", cyc, re.cyc);
               chk("rsp_data", s1v ? s1d : s0d, re.data);
            end
         end
         if (men) begin
            if (bus_q.size() == 0) flag("unexpected_mem_en");
            else begin
               be = bus_q.pop_front();
               chk("mem_cycle", cyc, be.cyc);
               chk("mem_we", {31'd0, mwe}, {31'd0, be.we});
               chk("mem_addr", ma, be.addr);
               chk("mem_wdata", mwd, be.wdata);
            end
         end
         if (bsy && (rdy0 || rdy1)) flag("ready_while_busy");
         if (rdy0 && rdy1)          flag("both_ready");
         if (mwe && !men)           flag("mem_we_without_en");
         if (!bsy && (ma != 0 || mwd != 0)) flag("mem_bus_nonzero_idle");
         if (rdy0) rdy0_hi++;
      end
   end

   // ------------------------------------------------------------ drivers
   task automatic issue(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expd, output int t);
      int n = 0;
      if (port == 0) begin r0v = 1'b1; r0we = we; r0a = addr; r0d = wdata; end
      else           begin r1v = 1'b1; r1we = we; r1a = addr; r1d = wdata; end
      @(negedge clk);
      while (!(port == 0 ? rdy0 : rdy1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         flag("accept_timeout");
         t = -1;
      end else begin
         t = cyc;
         exp_q.push_back('{port, expd, cyc + 2 + cur_lat});
         bus_q.push_back('{cyc + 1, we, addr, wdata});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drop(input int port);
      if (port == 0) r0v = 1'b0;
      else           r1v = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bsy) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) flag("drain_timeout");
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      bus_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- tests
   initial begin
      int t, ta0, tb0, ta1, tb1, t1, t2, t3, bc;
      rst = 1'b1; sel = 0; cur_lat = 2;
      r0v = 1'b0; r0we = 1'b0; r0a = '0; r0d = '0;
      r1v = 1'b0; r1we = 1'b0; r1a = '0; r1d = '0;

      // Reset: ready forced low even with a pending valid.
      r0v = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", {31'd0, rdy0}, 32'd0);
      @(posedge clk);
      #1;
      r0v = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, bsy}, 32'd0);
      chk("post_rst_state", {30'd0, st}, {30'd0, IDLE});
      chk("post_rst_rsp0_rdata", s0d, 32'd0);
      chk("post_rst_rsp1_rdata", s1d, 32'd0);
      chk("post_rst_mem", {men, mwe, s0v, s1v}, 32'd0);
      @(posedge clk);
      #1;

      // 1: port 0 read of 0x10.
      issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, t);
      drop(0);
      drain();

      // 2: port 1 write; rdata must be 0, port 0 rdata must hold.
      issue(1, 1'b1, 32'h20, 32'h12345678, 32'h0, t);
      drop(1);
      drain();
      chk("hold_rsp0_rdata", s0d, 32'hDEADBEEF);

      // 3: both ports continuously valid.
      do_reset();
`ifdef DMEM_ARB_RR_EN
      fork
         begin
            issue(0, 1'b0, 32'h30, 32'h0, 32'hC0DE0030, ta0);
            issue(0, 1'b0, 32'h34, 32'h0, 32'hC0DE0034, tb0);
            drop(0);
         end
         begin
            issue(1, 1'b0, 32'h38, 32'h0, 32'hC0DE0038, ta1);
            issue(1, 1'b0, 32'h3C, 32'h0, 32'hC0DE003C, tb1);
            drop(1);
         end
      join
      chk("rr_first0_then1", ta1 - ta0, 32'd5);
      chk("rr_1_then0",      tb0 - ta1, 32'd5);
      chk("rr_0_then1",      tb1 - tb0, 32'd5);
`else
      r0v = 1'b1; r0we = 1'b0; r0a = 32'h30; r0d = 32'h0;
      rdy0_hi = 0;
      issue(1, 1'b0, 32'h38, 32'h0, 32'hC0DE0038, ta1);
      issue(1, 1'b0, 32'h3C, 32'h0, 32'hC0DE003C, tb1);
      chk("fixed_gap_a", tb1 - ta1, 32'd5);
      issue(1, 1'b0, 32'h40, 32'h0, 32'hC0DE0040, ta1);
      chk("fixed_gap_b", ta1 - tb1, 32'd5);
      issue(1, 1'b1, 32'h44, 32'hCAFEF00D, 32'h0, tb1);
      chk("fixed_gap_c", tb1 - ta1, 32'd5);
      drop(0);
      drop(1);
      chk("fixed_rdy0_never", rdy0_hi, 32'd0);
`endif
      drain();

      // 4: reset during WAIT of a port 0 read.
      issue(0, 1'b0, 32'h50, 32'h0, 32'hC0DE0050, t);
      drop(0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'd0, bsy}, 32'd0);
      chk("midrst_mem_en", {31'd0, men}, 32'd0);
      chk("midrst_rsp0_rdata", s0d, 32'd0);
      repeat (6) @(posedge clk);
      #1;
      issue(0, 1'b0, 32'h4, 32'h0, 32'hC0DE0004, t);
      drop(0);
      drain();

      // 5: MEM_LAT=1, three back-to-back port 0 reads.
      sel = 1; cur_lat = 1;
      repeat (2) @(posedge clk);
      #1;
      bc = 0;
      fork
         begin
            issue(0, 1'b0, 32'h60, 32'h0, 32'hC0DE0060, t1);
            issue(0, 1'b0, 32'h64, 32'h0, 32'hC0DE0064, t2);
            issue(0, 1'b0, 32'h68, 32'h0, 32'hC0DE0068, t3);
            drop(0);
         end
         begin
            int n = 0;
            @(negedge clk);
            while (!rdy0 && n < 50) begin
               @(negedge clk);
               n++;
            end
            for (int i = 0; i < 12; i++) begin
               if (bsy) bc++;
               @(negedge clk);
            end
         end
      join
      chk("lat1_accept_gap1", t2 - t1, 32'd4);
      chk("lat1_accept_gap2", t3 - t2, 32'd4);
      chk("lat1_busy_cycles", bc, 32'd9);
      drain();

      // 6: MEM_LAT=7, port 0 arrives while port 1 waits.
      sel = 2; cur_lat = 7;
      repeat (2) @(posedge clk);
      #1;
      issue(1, 1'b0, 32'h70, 32'h0, 32'hC0DE0070, t1);
      drop(1);
      issue(0, 1'b0, 32'h74, 32'h0, 32'hC0DE0074, t2);
      drop(0);
      chk("lat7_port0_accept", t2 - t1, 32'd10);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 = CPU load/store path, port 1 = debug/loader path (memory preload, register-dump readback).
- Sequences each access through issue, wait and response phases for a memory with fixed read latency.
- Returns read data or a write acknowledge to the requester that owns the access.
- Sits between the core datapath and the data memory; the core stalls on `req0_ready` = 0.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  port 0 request.
- req0_we  in  1  port 0 write (1) / read (0).
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_ready  out  1  port 0 accept (combinational).
- rsp0_valid  out  1  port 0 response strobe.
- rsp0_rdata  out  DATA_W  port 0 read data.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grant is computed combinationally from the valids. `reqN_ready` = 1 only for the granted port.
  - Accept occurs when valid & ready in cycle T. On accept: latch owner, we, addr, wdata; go to ISSUE.
- ISSUE (T+1):
  - `mem_en` = 1; `mem_we` = latched we; `mem_addr`/`mem_wdata` = latched values.
  - Load `lat_cnt` = MEM_LAT-1; go to WAIT.
- WAIT (T+2 .. T+1+MEM_LAT):
  - `mem_en` = 0.
  - Decrement `lat_cnt`. At 0: capture `mem_rdata` (forced to 0 if the access was a write) into the owner's rdata register; go to DONE.
- DONE (T+2+MEM_LAT):
  - Owner's `rspN_valid` = 1 for exactly one cycle; the other port's `rsp_valid` stays 0. Go to IDLE.
- Timing:
  - Earliest next accept is T+3+MEM_LAT, so one transaction every MEM_LAT+3 cycles.
  - `rspN_rdata` holds its value until that port's next response.
- Handshake rules:
  - Requester holds valid/we/addr/wdata stable until ready.
  - Valid deasserted before ready: request dropped, no side effect.
  - Both `ready` outputs are 0 in every state except IDLE.
- Arbitration (base build): fixed priority, port 1 over port 0. Simultaneous valids in IDLE grant port 1.
- Memory signals:
  - `mem_we` is asserted only in ISSUE and only for writes.
  - `mem_addr`/`mem_wdata` hold latched values in ISSUE..DONE and are 0 in IDLE.
- Reset:
  - While `rst` is high, both `ready` outputs are forced to 0.
  - At the clock edge with `rst` = 1: state = IDLE, `lat_cnt` = 0, `rsp0_valid`/`rsp1_valid` = 0, `rsp0_rdata`/`rsp1_rdata` = 0, owner = 0, round-robin pointer favours port 0.
  - All outputs are 0 in the cycle after reset.
- Reset mid-operation (ISSUE/WAIT/DONE): the transaction is abandoned. No `rsp_valid` is produced, and a pending DONE strobe is suppressed.
- Parameter check: MEM_LAT outside 1..7 is an elaboration error.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port; it is updated on each accept to the non-granted port.
  - With both ports continuously valid, grants alternate 0,1,0,1 starting with port 0 after reset.
  - A single requester is granted regardless of the pointer.
- Undefined: fixed priority as in Behaviour; the pointer logic is absent.

Decomposition:
- Package `dmem_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - port index constants PORT_CPU = 0, PORT_DBG = 1;
  - LAT_W = 3.
- Sub-module `dmem_arb_pick`: combinational grant from the two valids plus pointer; the pointer register lives in the parent and only exists under DMEM_ARB_RR_EN.
- FSM, latches and counter live in the parent.

Test Plan:
1. MEM_LAT=2; port 0 read of 0x10, memory model returns 0xDEADBEEF:
   - `req0_ready` high at T;
   - `mem_en` with `mem_addr` = 0x10 at T+1 only;
   - `rsp0_valid` at T+4 with `rsp0_rdata` = 0xDEADBEEF;
   - `rsp1_valid` stays 0.
2. MEM_LAT=2; port 1 write addr 0x20, data 0x12345678:
   - `mem_en` = `mem_we` = 1 at T+1 only, `mem_wdata` = 0x12345678;
   - `rsp1_valid` at T+4 with `rsp1_rdata` = 0.
3. Both valid continuously for 4 transactions:
   - without the macro, all grants go to port 1 and `req0_ready` is never 1;
   - with DMEM_ARB_RR_EN, grant order is 0,1,0,1.
4. Reset pulsed for 1 cycle during WAIT of a port 0 read:
   - next cycle `busy` = 0 and `mem_en` = 0;
   - no `rsp0_valid`;
   - a subsequent port 0 read of 0x4 completes normally at T+4.
5. MEM_LAT=1; port 0 holds valid for 3 back-to-back reads:
   - accepts at T, T+4, T+8;
   - `busy` is high 3 of every 4 cycles;
   - `rsp0_valid` at T+3, T+7, T+11.
6. MEM_LAT=7; port 0 valid raised while port 1's access is in WAIT:
   - `req0_ready` stays 0 until IDLE;
   - port 0 is accepted the cycle after port 1's `rsp1_valid`.
